seg_scan_capture: RTL and testbench

Receive-side companion to the multiplexed 7-segment display path: samples the scanned segment bus (`seg`, `dp`, one-hot digit enable) produced by the NCO/counter/display chain and rebuilds the six displayed digits as BCD. It deglitches each scan slot and flags illegal patterns. It publishes a complete 6-digit frame with a one-cycle valid strobe. It sits beside the display driver, on the same clock, as an on-chip self-check / readback block.

---
 rtl/seg_scan_capture.sv | 130 +++++++++++++
 tb/tb_seg_scan_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Readback of the multiplexed 7-segment scan bus: deglitches each digit slot, decodes to BCD and
// publishes complete 6-digit frames with a one-cycle valid strobe.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  input  logic        i_err_clr,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_valid,
  output logic [1:0]  o_err,
  output logic        o_stall
);

  localparam int unsigned      IdleW   = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]       CntMax  = 8'(STABLE_CYC);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StStall} state_e;

  state_e           state;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [5:0]       r_enb;
  logic [7:0]       cnt;
  logic [5:0]       seen;
  logic [23:0]      shadow_dig;
  logic [5:0]       shadow_dp;
  logic             frame_pend;
  logic [IdleW-1:0] idle_cnt;

  logic       chg, step, multi, accept, multi_err, illegal;
  logic [2:0] slot;
  logic [3:0] dec;
  logic [5:0] seen_nxt;

  always_comb begin
    // Compare the value about to be registered with the current one, so cnt restarts on the
    // same edge the new pattern lands in r_*.
    chg       = {i_seg_enb, i_seg, i_seg_dp} != {r_enb, r_seg, r_dp};
    step      = !chg && (cnt == CntMax - 8'd1);
    multi     = (r_enb & (r_enb - 6'd1)) != 6'd0;
    accept    = step && (r_enb != 6'd0) && !multi;
    multi_err = step && multi;
    slot = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (r_enb[k]) slot = 3'(k);
    end
    case (r_seg)
      7'h3F:   dec = 4'd0;
      7'h06:   dec = 4'd1;
      7'h5B:   dec = 4'd2;
      7'h4F:   dec = 4'd3;
      7'h66:   dec = 4'd4;
      7'h6D:   dec = 4'd5;
      7'h7D:   dec = 4'd6;
      7'h07:   dec = 4'd7;
      7'h7F:   dec = 4'd8;
      7'h6F:   dec = 4'd9;
      7'h00:   dec = 4'hF;
      default: dec = 4'hE;
    endcase
    illegal  = dec == 4'hE;
    seen_nxt = seen | (6'd1 << slot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      r_seg         <= '0;
      r_dp          <= 1'b0;
      r_enb         <= '0;
      cnt           <= '0;
      seen          <= '0;
      shadow_dig    <= 24'hFFFFFF;
      shadow_dp     <= '0;
      frame_pend    <= 1'b0;
      idle_cnt      <= '0;
      o_digits      <= 24'hFFFFFF;
      o_dp          <= '0;
      o_frame_valid <= 1'b0;
      o_err         <= '0;
      o_stall       <= 1'b0;
    end else begin
      r_seg <= i_seg;
      r_dp  <= i_seg_dp;
      r_enb <= i_seg_enb;
      if (chg)              cnt <= '0;
      else if (cnt < CntMax) cnt <= cnt + 8'd1;

      o_frame_valid <= frame_pend;
      frame_pend    <= 1'b0;
      if (frame_pend) begin
        o_digits <= shadow_dig;
        o_dp     <= shadow_dp;
      end
      // Set wins over a same-cycle clear.
      o_err <= (o_err & ~{2{i_err_clr}}) | {multi_err, accept && illegal};

      if (accept) begin
        shadow_dig[{slot, 2'b00} +: 4] <= dec;
        shadow_dp[slot]                <= r_dp;
        idle_cnt                       <= '0;
        o_stall                        <= 1'b0;
        if (seen_nxt == 6'h3F) begin
          seen       <= '0;
          frame_pend <= 1'b1;
          state      <= StIdle;
        end else begin
          seen  <= seen_nxt;
          state <= StCollect;
        end
      end else if (state != StStall) begin
        if (idle_cnt == IdleMax) begin
          state   <= StStall;
          seen    <= '0;
          o_stall <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: run-length reference model feeds a frame scoreboard; a negedge
// monitor compares frames, flags and held outputs.
module tb_seg_scan_capture;
  localparam int unsigned STABLE = 4;
  localparam int unsigned TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  i_seg = '0;
  logic        i_seg_dp = 1'b0;
  logic [5:0]  i_seg_enb = '0;
  logic        i_err_clr = 1'b0;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_frame_valid;
  logic [1:0]  o_err;
  logic        o_stall;

  always #10 clk = ~clk;

  seg_scan_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_seg        (i_seg),
    .i_seg_dp     (i_seg_dp),
    .i_seg_enb    (i_seg_enb),
    .i_err_clr    (i_err_clr),
    .o_digits     (o_digits),
    .o_dp         (o_dp),
    .o_frame_valid(o_frame_valid),
    .o_err        (o_err),
    .o_stall      (o_stall)
  );

  typedef struct {
    logic [23:0] dig;
    logic [5:0]  dp;
    int          cyc;
  } frame_t;

  frame_t     exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_exp = 0;
  int         n_got = 0;
  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    if (p == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++) if (lut[i] == p) return 4'(i);
    return 4'hE;
  endfunction

  // Reference model: a digit is taken once its input pattern has been seen on STABLE+1 edges.
  logic [13:0] m_prev;
  int          m_run;
  logic [5:0]  m_seen;
  logic [3:0]  m_dig [6];
  logic [5:0]  m_dpv;
  logic        m_stall;
  logic [1:0]  m_err;
  int          m_since;
  int          m_cyc = 0;
  logic        m_pend;
  logic [23:0] m_pend_dig, m_pub_dig;
  logic [5:0]  m_pend_dp, m_pub_dp;

  always @(posedge clk or negedge rst_n) begin : model
    logic [13:0] cur;
    logic [1:0]  newerr;
    logic [23:0] fd;
    int          k;
    logic [3:0]  val;
    logic        acc;
    if (!rst_n) begin
      m_prev = '0; m_run = 1; m_seen = '0; m_dpv = '0; m_stall = 1'b0; m_err = '0;
      m_since = 0; m_pend = 1'b0; m_pub_dig = 24'hFFFFFF; m_pub_dp = '0;
      for (int i = 0; i < 6; i++) m_dig[i] = 4'hF;
    end else begin
      m_cyc++;
      if (m_pend) begin
        m_pub_dig = m_pend_dig;
        m_pub_dp  = m_pend_dp;
        m_pend    = 1'b0;
      end
      cur = {i_seg_enb, i_seg, i_seg_dp};
      if (cur == m_prev) m_run++;
      else begin
        m_run  = 1;
        m_prev = cur;
      end
      newerr = '0;
      acc    = 1'b0;
      k      = 0;
      val    = 4'hF;
      if (m_run == STABLE + 1) begin
        if ($countones(cur[13:8]) > 1) newerr[1] = 1'b1;
        else if ($countones(cur[13:8]) == 1) begin
          acc = 1'b1;
          for (int i = 0; i < 6; i++) if (cur[8+i]) k = i;
          val = ref_decode(cur[7:1]);
          if (val == 4'hE) newerr[0] = 1'b1;
        end
      end
      m_err = (i_err_clr ? 2'b00 : m_err) | newerr;
      if (acc) begin
        m_dig[k]  = val;
        m_dpv[k]  = cur[0];
        m_seen[k] = 1'b1;
        m_since   = 0;
        m_stall   = 1'b0;
        if (m_seen == 6'h3F) begin
          for (int i = 0; i < 6; i++) fd[4*i +: 4] = m_dig[i];
          exp_q.push_back('{fd, m_dpv, m_cyc + 1});
          n_exp++;
          m_pend     = 1'b1;
          m_pend_dig = fd;
          m_pend_dp  = m_dpv;
          m_seen     = '0;
        end
      end else if (!m_stall) begin
        m_since++;
        if (m_since == TMO) begin
          m_stall = 1'b1;
          m_seen  = '0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    frame_t f;
    if (rst_n) begin
      check("stall", 32'(o_stall), 32'(m_stall));
      check("err", 32'(o_err), 32'(m_err));
      check("digits_held", 32'(o_digits), 32'(m_pub_dig));
      check("dp_held", 32'(o_dp), 32'(m_pub_dp));
      while (exp_q.size() > 0 && exp_q[0].cyc < m_cyc) begin
        f = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL frame_missing actual none required frame at cycle %0d", f.cyc);
      end
      if (o_frame_valid) begin
        n_got++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual strobe at cycle %0d required none", m_cyc);
        end else begin
          f = exp_q.pop_front();
          check("frame_cycle", 32'(m_cyc), 32'(f.cyc));
          check("frame_digits", 32'(o_digits), 32'(f.dig));
          check("frame_dp", 32'(o_dp), 32'(f.dp));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    cycles(n);
  endtask

  task automatic show(input int s, input logic [6:0] p, input logic dp, input int hold,
                      input int gap);
    drive(6'(1 << s), p, dp, hold);
    drive(6'd0, 7'd0, 1'b0, gap);
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    cycles(1);
    i_err_clr = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin : stim
    logic [5:0] enb;
    logic [6:0] pat;
    int         r;
    cycles(2);
    check("rst_digits", 32'(o_digits), 32'h00FFFFFF);
    check("rst_dp", 32'(o_dp), 32'd0);
    check("rst_valid", 32'(o_frame_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    for (int s = 0; s < 6; s++) show(s, lut[s], 1'b0, 8, 2);
    cycles(6);
    sample();
    check("frame1_digits", 32'(o_digits), 32'h00543210);
    check("frame1_dp", 32'(o_dp), 32'd0);
    resync();

    // Slot 2 glitches through 8 before settling on 9.
    for (int s = 0; s < 6; s++) begin
      if (s == 2) begin
        drive(6'b000100, 7'h7F, 1'b0, 3);
        show(2, 7'h6F, 1'b0, 8, 2);
      end else show(s, lut[s], 1'b0, 8, 2);
    end
    cycles(6);
    sample();
    check("glitch_digit2", 32'(o_digits[11:8]), 32'd9);
    resync();

    for (int s = 0; s < 6; s++) show(s, (s == 4) ? 7'h49 : lut[(s + 6) % 10], 1'b1, 8, 2);
    cycles(6);
    sample();
    check("illegal_digit4", 32'(o_digits[19:16]), 32'hE);
    check("illegal_err", 32'(o_err), 32'd1);
    resync();
    pulse_clr();
    sample();
    check("err_cleared", 32'(o_err), 32'd0);
    resync();

    for (int s = 0; s < 3; s++) show(s, lut[s + 1], 1'b0, 8, 2);
    drive(6'b000011, 7'h06, 1'b0, 10);
    drive(6'd0, 7'd0, 1'b0, 2);
    for (int s = 3; s < 6; s++) show(s, lut[s + 1], 1'b0, 8, 2);
    cycles(6);
    sample();
    check("multi_err1", 32'(o_err[1]), 32'd1);
    check("multi_frame", 32'(o_digits), 32'h00654321);
    resync();
    pulse_clr();

    for (int s = 0; s < 3; s++) show(s, lut[7 + s], 1'b0, 8, 2);
    drive(6'd0, 7'd0, 1'b0, 70);
    sample();
    check("stall_high", 32'(o_stall), 32'd1);
    resync();
    drive(6'b000001, lut[9], 1'b0, 8);
    sample();
    check("stall_cleared", 32'(o_stall), 32'd0);
    resync();
    drive(6'd0, 7'd0, 1'b0, 2);
    for (int s = 1; s < 6; s++) show(s, lut[9 - s], 1'b0, 8, 2);
    cycles(6);
    sample();
    check("stall_frame", 32'(o_digits), 32'h00456789);
    resync();

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 17) pat = lut[r % 10];
      else if (r == 17) pat = 7'h00;
      else pat = 7'($urandom);
      enb = 6'(1 << $urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) enb = enb | 6'b100000 | 6'b000001;
      i_err_clr = ($urandom_range(0, 7) == 0);
      drive(enb, pat, 1'($urandom), $urandom_range(2, 9));
      i_err_clr = 1'b0;
      drive(6'd0, 7'd0, 1'b0, $urandom_range(0, 3));
    end
    for (int s = 0; s < 6; s++) show(s, lut[(s * 3) % 10], 1'($urandom), 6, 1);
    cycles(6);

    for (int s = 0; s < 4; s++) show(s, lut[s + 2], 1'b1, 8, 2);
    #3;
    rst_n = 1'b0;
    #2;
    check("async_digits", 32'(o_digits), 32'h00FFFFFF);
    check("async_dp", 32'(o_dp), 32'd0);
    check("async_valid", 32'(o_frame_valid), 32'd0);
    check("async_err", 32'(o_err), 32'd0);
    check("async_stall", 32'(o_stall), 32'd0);
    resync();
    cycles(1);
    rst_n = 1'b1;
    for (int s = 4; s < 6; s++) show(s, lut[s], 1'b0, 8, 2);
    cycles(10);

    check("frame_count", 32'(n_got), 32'(n_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
